hazard_controller: RTL and testbench

Pipeline hazard sequencer for the 5-stage processor. It sits beside the decode stage and watches the instruction in ID and the producers in EX and MEM. It drives operand-forwarding selects, the load-use stall, and the taken-branch flush for the pipeline registers. The same ALU result path feeds every forward, so this block decides each cycle which stage's result the next ALU operation consumes.

---
 rtl/hazard_controller.sv | 71 +++++++
 tb/tb_hazard_controller.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: forwarding selects, load-use stall and taken-branch flush for a 5-stage pipeline.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_controller #(
  parameter int REG_W = 3
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_op,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);
  localparam logic [3:0] OP_R = 4'h0, OP_SW = 4'h4, OP_BEQ = 4'h5, OP_BNE = 4'h6;
  typedef enum logic [1:0] {RUN = 2'b00, LD_STALL = 2'b01, BR_FLUSH = 2'b10} state_t;
  state_t st;
  logic uses_rt, a_ex, a_mem, b_ex, b_mem, hz, br, stall;
  always_comb begin
    uses_rt = id_op inside {OP_R, OP_SW, OP_BEQ, OP_BNE};
    a_ex = |id_rs && id_rs == ex_rd && ex_reg_write && !ex_mem_read;
    a_mem = |id_rs && id_rs == mem_rd && mem_reg_write;
    b_ex = uses_rt && |id_rt && id_rt == ex_rd && ex_reg_write && !ex_mem_read;
    b_mem = uses_rt && |id_rt && id_rt == mem_rd && mem_reg_write;
    hz = st != LD_STALL && ex_mem_read && |ex_rd &&
         (ex_rd == id_rs || (uses_rt && ex_rd == id_rt));
    // A branch cannot resolve from the squashed slot, so a flush never repeats back to back
    br = st != BR_FLUSH && br_resolve && br_taken;
    stall = hz && !br && !reset;
    pc_en = !reset && !stall;
    if_id_en = !reset && !stall;
    if_id_flush = reset || br;
    id_ex_bubble = reset || br || stall;
    fwd_a = (reset || stall) ? 2'b00 : a_ex ? 2'b01 : a_mem ? 2'b10 : 2'b00;
    fwd_b = (reset || stall) ? 2'b00 : b_ex ? 2'b01 : b_mem ? 2'b10 : 2'b00;
  end
  assign state = st;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= RUN;
`ifdef HAZARD_STATS_EN
      stall_cnt <= '0;
      flush_cnt <= '0;
`endif
    end else begin
      st <= br ? BR_FLUSH : hz ? LD_STALL : RUN;
`ifdef HAZARD_STATS_EN
      if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br && ~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
`endif
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed pipeline scenarios then random traffic, checked against a pipeline-rule model.
module tb_hazard_controller;
  localparam logic [3:0] OP_R = 4'h0, OP_ANDI = 4'h2, OP_LW = 4'h3, OP_SW = 4'h4, OP_BEQ = 4'h5, OP_BNE = 4'h6;
  logic clk, reset;
  logic [3:0] id_op;
  logic [2:0] id_rs, id_rt, ex_rd, mem_rd;
  logic ex_reg_write, ex_mem_read, mem_reg_write, br_resolve, br_taken;
  logic [1:0] fwd_a, fwd_b, state;
  logic pc_en, if_id_en, if_id_flush, id_ex_bubble;
  int checks = 0, passed = 0;
  int mode = 0;
  int n_stall = 0, n_flush = 0;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  hazard_controller dut (
    .clk(clk), .reset(reset), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .br_resolve(br_resolve), .br_taken(br_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit same(input logic [2:0] a, input logic [2:0] b);
    return a != 0 && a == b;
  endfunction

  function automatic int src_fwd(input logic [2:0] r, input bit used);
    if (!used) return 0;
    if (same(ex_rd, r) && ex_reg_write && !ex_mem_read) return 1;
    if (same(mem_rd, r) && mem_reg_write) return 2;
    return 0;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic ew, input logic er, input logic [2:0] erd,
                       input logic mw, input logic [2:0] mrd, input logic bres, input logic bt);
    id_op = op; id_rs = rs; id_rt = rt;
    ex_reg_write = ew; ex_mem_read = er; ex_rd = erd;
    mem_reg_write = mw; mem_rd = mrd; br_resolve = bres; br_taken = bt;
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later, then the model advances at the rising edge.
  task automatic cyc();
    bit rt_used, ld_hit;
    int e_pc, e_ifid, e_fl, e_bub, e_a, e_b, nxt;
    #1;
    rt_used = id_op inside {OP_R, OP_SW, OP_BEQ, OP_BNE};
    ld_hit = ex_mem_read && (same(ex_rd, id_rs) || (rt_used && same(ex_rd, id_rt)));
    e_a = src_fwd(id_rs, 1); e_b = src_fwd(id_rt, rt_used);
    e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; nxt = 0;
    if (reset) begin
      e_pc = 0; e_ifid = 0; e_fl = 1; e_bub = 1; e_a = 0; e_b = 0;
    end else if (mode != 2 && br_resolve && br_taken) begin
      e_fl = 1; e_bub = 1; nxt = 2;
    end else if (mode != 1 && ld_hit) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_a = 0; e_b = 0; nxt = 1;
    end
    chk("state", state, mode);
    chk("pc_en", pc_en, e_pc);
    chk("if_id_en", if_id_en, e_ifid);
    chk("if_id_flush", if_id_flush, e_fl);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("fwd_a", fwd_a, e_a);
    chk("fwd_b", fwd_b, e_b);
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt, n_stall);
    chk("flush_cnt", flush_cnt, n_flush);
`endif
    @(posedge clk);
    mode = nxt;
    if (reset) begin n_stall = 0; n_flush = 0; end
    else begin
      if (nxt == 1) n_stall = (n_stall == 65535) ? n_stall : n_stall + 1;
      if (nxt == 2) n_flush = (n_flush == 65535) ? n_flush : n_flush + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc(); cyc();
    reset = 0;
    cyc();
    // LW r2 then ADD r3,r2,r1: one stall, then MEM forward
    drive(OP_R, 2, 1, 1, 1, 2, 0, 0, 0, 0); cyc();
    drive(OP_R, 2, 1, 0, 0, 0, 1, 2, 0, 0); cyc();
    chk("ld_fwd_a", fwd_a, 2);
    drive(OP_R, 4, 4, 1, 0, 4, 1, 4, 0, 0); cyc();
    drive(OP_R, 4, 4, 1, 0, 0, 1, 4, 0, 0); cyc();
    // taken branch flushes for one cycle; not-taken does nothing
    drive(OP_R, 1, 2, 0, 0, 0, 0, 0, 1, 1); cyc();
    drive(OP_R, 1, 2, 0, 0, 0, 0, 0, 0, 0); cyc();
    drive(OP_R, 1, 2, 0, 0, 0, 0, 0, 1, 0); cyc();
    // branch and load-use together: flush wins, no stall after
    drive(OP_R, 3, 1, 1, 1, 3, 0, 0, 1, 1); cyc();
    drive(OP_R, 3, 1, 0, 0, 0, 1, 3, 0, 0); cyc();
    chk("no_stall_after_flush", state, 0);
    // ANDI uses rs only
    drive(OP_ANDI, 2, 5, 1, 1, 2, 0, 0, 0, 0); cyc();
    drive(OP_ANDI, 1, 2, 0, 0, 0, 1, 2, 0, 0); cyc();
    drive(OP_ANDI, 1, 2, 1, 1, 2, 0, 0, 0, 0); cyc();
    // reset during LD_STALL aborts it
    drive(OP_SW, 6, 7, 1, 1, 7, 0, 0, 0, 0); cyc();
    reset = 1; cyc();
    reset = 0; drive(OP_LW, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
`ifdef HAZARD_STATS_EN
    for (int i = 0; i < 3; i++) begin
      drive(OP_BEQ, 1, 5, 1, 1, 5, 0, 0, 0, 0); cyc();
      drive(OP_BEQ, 1, 5, 0, 0, 0, 0, 0, 0, 0); cyc();
    end
    for (int i = 0; i < 2; i++) begin
      drive(OP_R, 1, 1, 0, 0, 0, 0, 0, 1, 1); cyc();
      drive(OP_R, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
    end
    chk("stall_cnt_3", stall_cnt, 3);
    chk("flush_cnt_2", flush_cnt, 2);
    reset = 1; cyc();
    reset = 0; cyc();
`endif
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(4'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
            3'($urandom), 1'($urandom), 3'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom));
      cyc();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
